pipeline_ctrl: RTL and testbench

Stall/flush sequencer for the five-stage pipelined CPU. It drives the write-enable and flush controls of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers. It arbitrates three hazard sources: data-memory wait states, load-use dependencies and taken branches. A wait-state FSM, a stall-cycle counter and an optional memory watchdog give the block real state.

---
 rtl/pipeline_ctrl_pkg.sv | 13 +
 rtl/pipeline_ctrl_hazard_unit.sv | 16 +
 rtl/pipeline_ctrl.sv | 127 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } pipe_state_e;

    localparam logic [4:0]  REG_ZERO      = 5'd0;
    localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipeline_ctrl_hazard_unit.sv
// Load-use detector: a load in EX whose rd feeds either source of the ID instruction.
module hazard_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] IDrs1_i,
    input  logic [4:0] IDrs2_i,
    input  logic [4:0] EXrd_i,
    input  logic       EXMemRead_i,
    output logic       loaduse_o
);

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign loaduse_o = EXMemRead_i && (EXrd_i != REG_ZERO) &&
                       ((EXrd_i == IDrs1_i) || (EXrd_i == IDrs2_i));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: memory wait > branch > load-use.
// Optional memory watchdog enabled with `define PIPE_CTRL_WATCHDOG_EN.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IDrs1_i,
    input  logic [4:0]       IDrs2_i,
    input  logic [4:0]       EXrd_i,
    input  logic             EXMemRead_i,
    input  logic             BranchTaken_i,
    input  logic             MemReq_i,
    input  logic             MemReady_i,
    output logic             PCWrite_o,
    output logic             IF_ID_Write_o,
    output logic             IF_ID_Flush_o,
    output logic             ID_EX_Flush_o,
    output logic             EX_MEM_Write_o,
    output logic             MEM_WB_Bubble_o,
    output logic [31:0]      StallCycles_o,
    output logic             Fault_o,
    output pipe_state_e      state_o,
    output logic [CNT_W-1:0] wait_cnt_o
);

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    pipe_state_e      state_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic [31:0]      stall_cnt_q;
    logic             loaduse;
    logic             memstall;
    logic             in_fault;

    hazard_unit u_hazard (
        .IDrs1_i     (IDrs1_i),
        .IDrs2_i     (IDrs2_i),
        .EXrd_i      (EXrd_i),
        .EXMemRead_i (EXMemRead_i),
        .loaduse_o   (loaduse)
    );

`ifdef PIPE_CTRL_WATCHDOG_EN
    assign in_fault = (state_q == FAULT);
`else
    assign in_fault = 1'b0;
`endif

    // In MEM_WAIT the request is already in flight, so only MemReady_i matters.
    assign memstall = ((state_q == RUN) && MemReq_i && !MemReady_i) ||
                      ((state_q == MEM_WAIT) && !MemReady_i);

    always_comb begin
        PCWrite_o       = 1'b1;
        IF_ID_Write_o   = 1'b1;
        IF_ID_Flush_o   = 1'b0;
        ID_EX_Flush_o   = 1'b0;
        EX_MEM_Write_o  = 1'b1;
        MEM_WB_Bubble_o = 1'b0;
        if (rst_i) begin
            PCWrite_o       = 1'b0;
            IF_ID_Write_o   = 1'b0;
            IF_ID_Flush_o   = 1'b1;
            ID_EX_Flush_o   = 1'b1;
            EX_MEM_Write_o  = 1'b0;
            MEM_WB_Bubble_o = 1'b1;
        end else if (in_fault || memstall) begin
            PCWrite_o       = 1'b0;
            IF_ID_Write_o   = 1'b0;
            EX_MEM_Write_o  = 1'b0;
            MEM_WB_Bubble_o = 1'b1;
        end else if (BranchTaken_i) begin
            IF_ID_Flush_o   = 1'b1;
            ID_EX_Flush_o   = 1'b1;
        end else if (loaduse) begin
            PCWrite_o       = 1'b0;
            IF_ID_Write_o   = 1'b0;
            ID_EX_Flush_o   = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (memstall && (stall_cnt_q != STALL_CNT_MAX))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            case (state_q)
                RUN: begin
                    if (MemReq_i && !MemReady_i) begin
                        state_q    <= MEM_WAIT;
                        wait_cnt_q <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (MemReady_i) begin
                        state_q <= RUN;
                    end else begin
                        // Holds at the timeout value so an unbounded wait cannot wrap.
                        if (wait_cnt_q != TIMEOUT_VAL)
                            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
`ifdef PIPE_CTRL_WATCHDOG_EN
                        if (wait_cnt_q == TIMEOUT_VAL - CNT_W'(1))
                            state_q <= FAULT;
`endif
                    end
                end
`ifdef PIPE_CTRL_WATCHDOG_EN
                FAULT: state_q <= FAULT;
`endif
                default: state_q <= RUN;
            endcase
        end
    end

    assign StallCycles_o = stall_cnt_q;
    assign Fault_o       = in_fault;
    assign state_o       = state_q;
    assign wait_cnt_o    = wait_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed table, corner-case sequences and random traffic vs. a reference model.
module tb_pipeline_ctrl;
    import pipe_ctrl_pkg::*;

`ifdef PIPE_CTRL_WATCHDOG_EN
    localparam bit WD = 1'b1;
    localparam int TO = 4;
`else
    localparam bit WD = 1'b0;
    localparam int TO = 255;
`endif

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] exrd;
        logic       memread;
        logic       br;
        logic       memreq;
        logic       memready;
    } in_t;

    // Control vector bits: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Write, MEM_WB_Bubble}
    localparam logic [5:0] C_DEF   = 6'b110010;
    localparam logic [5:0] C_LU    = 6'b000110;
    localparam logic [5:0] C_BR    = 6'b111110;
    localparam logic [5:0] C_MEM   = 6'b000001;
    localparam logic [5:0] C_RST   = 6'b001101;

    typedef struct {
        string      name;
        in_t        in;
        logic [5:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1, rs2, exrd;
    logic        memread, br, memreq, memready;
    logic        pcw, ifidw, ifidf, idexf, exmemw, bub;
    logic [31:0] stall_cycles;
    logic        fault;
    pipe_state_e state;
    logic [7:0]  wait_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    bit              m_wait, m_fault;
    int              m_wcnt;
    longint unsigned m_stall;
    vec_t            vecs[$];

    always #5 clk = ~clk;

    pipeline_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .IDrs1_i         (rs1),
        .IDrs2_i         (rs2),
        .EXrd_i          (exrd),
        .EXMemRead_i     (memread),
        .BranchTaken_i   (br),
        .MemReq_i        (memreq),
        .MemReady_i      (memready),
        .PCWrite_o       (pcw),
        .IF_ID_Write_o   (ifidw),
        .IF_ID_Flush_o   (ifidf),
        .ID_EX_Flush_o   (idexf),
        .EX_MEM_Write_o  (exmemw),
        .MEM_WB_Bubble_o (bub),
        .StallCycles_o   (stall_cycles),
        .Fault_o         (fault),
        .state_o         (state),
        .wait_cnt_o      (wait_cnt)
    );

    function automatic logic [5:0] ctl_now();
        return {pcw, ifidw, ifidf, idexf, exmemw, bub};
    endfunction

    function automatic bit model_memstall(in_t in);
        if (m_fault) return 1'b0;
        return (in.memreq && !in.memready) || (m_wait && !in.memready);
    endfunction

    // Expected controls straight from the priority rules.
    function automatic logic [5:0] model_ctl(in_t in, logic r);
        bit lu;
        lu = in.memread && (in.exrd != 5'd0) && (in.exrd == in.rs1 || in.exrd == in.rs2);
        if (r)                   return C_RST;
        if (m_fault)             return C_MEM;
        if (model_memstall(in))  return C_MEM;
        if (in.br)               return C_BR;
        if (lu)                  return C_LU;
        return C_DEF;
    endfunction

    task automatic model_clock(in_t in, logic r);
        bit ms;
        ms = model_memstall(in);
        if (r) begin
            m_wait = 0; m_fault = 0; m_wcnt = 0; m_stall = 0;
        end else if (!m_fault) begin
            if (ms) begin
                if (m_stall < 64'hFFFF_FFFF) m_stall++;
                if (m_wait) begin
                    m_wcnt++;
                    if (WD && m_wcnt >= TO) begin
                        m_fault = 1; m_wait = 0;
                    end
                end else begin
                    m_wait = 1; m_wcnt = 0;
                end
            end else begin
                m_wait = 0;
            end
        end
    endtask

    task automatic check_ctl(string name, logic [5:0] act, logic [5:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: ctl got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(in_t in, logic r, string name);
        @(negedge clk);
        rst = r;
        {rs1, rs2, exrd, memread, br, memreq, memready} = in;
        #1;
        check_ctl({name, "_ctl"}, ctl_now(), model_ctl(in, r));
    endtask

    task automatic clock_regs(in_t in, logic r, string name);
        pipe_state_e exp_state;
        @(posedge clk);
        model_clock(in, r);
        #1;
        exp_state = m_fault ? FAULT : (m_wait ? MEM_WAIT : RUN);
        check32({name, "_stall"}, stall_cycles, m_stall[31:0]);
        check32({name, "_fault"}, {31'd0, fault}, {31'd0, m_fault});
        check32({name, "_state"}, {30'd0, state}, {30'd0, exp_state});
    endtask

    task automatic step(in_t in, logic r, string name);
        apply(in, r, name);
        clock_regs(in, r, name);
    endtask

    function automatic in_t mk(logic [4:0] a, logic [4:0] b, logic [4:0] d,
                               logic mr, logic bt, logic rq, logic rdy);
        in_t t;
        t.rs1 = a; t.rs2 = b; t.exrd = d; t.memread = mr;
        t.br = bt; t.memreq = rq; t.memready = rdy;
        return t;
    endfunction

    task automatic add_vec(string n, in_t in, logic [5:0] e);
        vec_t v;
        v.name = n; v.in = in; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        in_t idle, t;
        idle = mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        rst = 1'b1;
        {rs1, rs2, exrd, memread, br, memreq, memready} = idle;
        m_wait = 0; m_fault = 0; m_wcnt = 0; m_stall = 0;

        // Reset cycle: forced control values, then RUN with cleared counters.
        apply(idle, 1'b1, "reset");
        check_ctl("reset_table", ctl_now(), C_RST);
        clock_regs(idle, 1'b1, "reset");
        step(idle, 1'b0, "post_reset");

        add_vec("idle",         mk(5'd1, 5'd2, 5'd3, 0, 0, 0, 0), C_DEF);
        add_vec("lu_rs2",       mk(5'd1, 5'd5, 5'd5, 1, 0, 0, 0), C_LU);
        add_vec("lu_rs1",       mk(5'd7, 5'd2, 5'd7, 1, 0, 0, 0), C_LU);
        add_vec("lu_x0",        mk(5'd0, 5'd4, 5'd0, 1, 0, 0, 0), C_DEF);
        add_vec("no_load",      mk(5'd5, 5'd5, 5'd5, 0, 0, 0, 0), C_DEF);
        add_vec("no_match",     mk(5'd4, 5'd5, 5'd3, 1, 0, 0, 0), C_DEF);
        add_vec("branch",       mk(5'd1, 5'd2, 5'd3, 0, 1, 0, 0), C_BR);
        add_vec("branch_lu",    mk(5'd1, 5'd5, 5'd5, 1, 1, 0, 0), C_BR);
        add_vec("mem_ready",    mk(5'd1, 5'd2, 5'd3, 0, 0, 1, 1), C_DEF);
        add_vec("mem_ready_lu", mk(5'd9, 5'd2, 5'd9, 1, 0, 1, 1), C_LU);
        foreach (vecs[i]) begin
            apply(vecs[i].in, 1'b0, vecs[i].name);
            check_ctl({vecs[i].name, "_table"}, ctl_now(), vecs[i].exp);
            clock_regs(vecs[i].in, 1'b0, vecs[i].name);
        end

        // Memory wait of 3 cycles, completing on the 4th.
        step(idle, 1'b1, "mw_rst");
        t = mk(5'd1, 5'd2, 5'd3, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            apply(t, 1'b0, "mw_wait");
            check_ctl("mw_wait_table", ctl_now(), C_MEM);
            clock_regs(t, 1'b0, "mw_wait");
        end
        t.memready = 1'b1;
        apply(t, 1'b0, "mw_done");
        check_ctl("mw_done_table", ctl_now(), C_DEF);
        clock_regs(t, 1'b0, "mw_done");
        check32("mw_stall_total", stall_cycles, 32'd3);
        check32("mw_back_to_run", {30'd0, state}, {30'd0, RUN});

        // Branch + load-use under memstall, branch serviced once ready.
        t = mk(5'd1, 5'd5, 5'd5, 1, 1, 1, 0);
        apply(t, 1'b0, "sim_stall");
        check_ctl("sim_stall_table", ctl_now(), C_MEM);
        clock_regs(t, 1'b0, "sim_stall");
        t.memready = 1'b1;
        apply(t, 1'b0, "sim_branch");
        check_ctl("sim_branch_table", ctl_now(), C_BR);
        clock_regs(t, 1'b0, "sim_branch");

        // Reset while waiting with 7 stall cycles accumulated.
        step(idle, 1'b1, "rmw_rst0");
        t = mk(5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
        for (int i = 0; i < 7; i++) step(t, 1'b0, "rmw_wait");
        check32("rmw_stall7", stall_cycles, 32'd7);
        apply(t, 1'b1, "rmw_rst");
        check_ctl("rmw_rst_table", ctl_now(), C_RST);
        clock_regs(t, 1'b1, "rmw_rst");
        check32("rmw_stall0", stall_cycles, 32'd0);
        check32("rmw_fault0", {31'd0, fault}, 32'd0);
        step(idle, 1'b0, "rmw_run");

        // Long wait: watchdog build faults after TO wait cycles, default build never does.
        t = mk(5'd1, 5'd2, 5'd1, 1, 1, 1, 0);
        for (int i = 0; i < 12; i++) step(t, 1'b0, "long_wait");
        t.memready = 1'b1;
        step(t, 1'b0, "long_ready");
        check32("long_fault", {31'd0, fault}, {31'd0, WD});
        step(idle, 1'b1, "long_rst");
        check32("long_fault_clr", {31'd0, fault}, 32'd0);

        // Random traffic with small register numbers to provoke hits.
        for (int i = 0; i < 600; i++) begin
            logic r;
            t = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) != 0));
            r = ($urandom_range(0, 60) == 0);
            step(t, r, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
